// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle add/sub/logic ops plus iterative shifts and shift-add
// multiply behind a start/ready/done handshake, with registered result and C/Z/S/V flags.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             start,
  input  logic [4:0]       OPCODE,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             CFlag,
  output logic             ZeroFlag,
  output logic             SignFlag,
  output logic             VFlag,
  output logic             ill_op
);

  localparam int             MSB     = WIDTH - 1;
  localparam logic [WIDTH:0] ONE_W   = (WIDTH+1)'(1);
  localparam logic [SHW:0]   CNT_ONE = (SHW+1)'(1);
  localparam logic [SHW:0]   CNT_MUL = (SHW+1)'(WIDTH);

  typedef enum logic [4:0] {
    OP_ADD = 5'd0,  OP_ADC = 5'd1,  OP_SUB = 5'd2,  OP_INC = 5'd3,  OP_DEC = 5'd4,
    OP_AND = 5'd5,  OP_OR  = 5'd6,  OP_XOR = 5'd7,  OP_NOT = 5'd8,  OP_CMP = 5'd9,
    OP_SHL = 5'd10, OP_SHR = 5'd11, OP_SAR = 5'd12, OP_MUL = 5'd13
  } opcode_e;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL} state_e;

  typedef struct packed {
    logic [WIDTH-1:0] r;
    logic             c;
    logic             v;
    logic             wr_out;
    logic             wr_c;
  } alu_res_t;

  state_e           state, state_nx;
  logic [SHW:0]     cnt;
  logic [4:0]       op_q;
  logic [WIDTH-1:0] acc_hi, acc_lo, mcand;
  logic [SHW-1:0]   shamt;
  logic             is_shift, legal, last;
  logic [WIDTH:0]   sum;
  alu_res_t         alu;
  logic [WIDTH-1:0] sh_nx;
  logic             sh_c;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx;

  assign shamt    = in_b[SHW-1:0];
  assign is_shift = (OPCODE == OP_SHL) || (OPCODE == OP_SHR) || (OPCODE == OP_SAR);
  assign legal    = (OPCODE <= OP_MUL);
  assign last     = (cnt == CNT_ONE);
  assign ready    = (state == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst)         state <= S_IDLE;
    else if (enable) state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) begin
        if (is_shift && shamt != '0) state_nx = S_SHIFT;
        else if (OPCODE == OP_MUL)   state_nx = S_MUL;
      end
      S_SHIFT, S_MUL: if (last) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Single-cycle ops; arithmetic runs at WIDTH+1 so the top bit is carry/borrow.
  always_comb begin
    sum        = '0;
    alu.r      = out;
    alu.c      = CFlag;
    alu.v      = 1'b0;
    alu.wr_out = 1'b1;
    alu.wr_c   = 1'b0;
    case (OPCODE)
      OP_ADD: begin
        sum   = {1'b0, in_a} + {1'b0, in_b};
        alu.v = (in_a[MSB] == in_b[MSB]) && (sum[MSB] != in_a[MSB]);
      end
      OP_ADC: begin
        sum   = {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, CFlag};
        alu.v = (in_a[MSB] == in_b[MSB]) && (sum[MSB] != in_a[MSB]);
      end
      OP_SUB: begin
        sum   = {1'b0, in_a} - {1'b0, in_b};
        alu.v = (in_a[MSB] != in_b[MSB]) && (sum[MSB] != in_a[MSB]);
      end
      OP_INC: begin
        sum   = {1'b0, in_a} + ONE_W;
        alu.v = !in_a[MSB] && sum[MSB];
      end
      OP_DEC: begin
        sum   = {1'b0, in_a} - ONE_W;
        alu.v = in_a[MSB] && !sum[MSB];
      end
      OP_CMP: begin
        sum        = {1'b0, in_b} - {1'b0, in_a};
        alu.v      = (in_b[MSB] != in_a[MSB]) && (sum[MSB] != in_b[MSB]);
        alu.wr_out = 1'b0;
      end
      OP_AND: alu.r = in_a & in_b;
      OP_OR:  alu.r = in_a | in_b;
      OP_XOR: alu.r = in_a ^ in_b;
      OP_NOT: alu.r = ~in_a;
      OP_SHL, OP_SHR, OP_SAR: alu.r = in_a;  // zero shift amount only
      default: ;
    endcase
    if (OPCODE <= OP_DEC || OPCODE == OP_CMP) begin
      alu.wr_c = 1'b1;
      alu.r    = sum[MSB:0];
      alu.c    = sum[WIDTH];
    end
  end

  always_comb begin
    sh_nx = {acc_lo[MSB-1:0], 1'b0};
    sh_c  = acc_lo[MSB];
    if (op_q == OP_SHR) begin
      sh_nx = {1'b0, acc_lo[MSB:1]};
      sh_c  = acc_lo[0];
    end else if (op_q == OP_SAR) begin
      sh_nx = {acc_lo[MSB], acc_lo[MSB:1]};
      sh_c  = acc_lo[0];
    end
  end

  // Multiplier bits retire from acc_lo's bottom while product bits enter from the top.
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
  assign mul_hi_nx = mul_sum[WIDTH:1];
  assign mul_lo_nx = {mul_sum[0], acc_lo[MSB:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      out      <= '0;
      out_hi   <= '0;
      CFlag    <= 1'b0;
      ZeroFlag <= 1'b0;
      SignFlag <= 1'b0;
      VFlag    <= 1'b0;
      done     <= 1'b0;
      ill_op   <= 1'b0;
      cnt      <= '0;
      op_q     <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      mcand    <= '0;
    end else if (enable) begin
      done   <= 1'b0;
      ill_op <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          op_q <= OPCODE;
          if (!legal) begin
            done   <= 1'b1;
            ill_op <= 1'b1;
          end else if (OPCODE == OP_MUL) begin
            acc_hi <= '0;
            acc_lo <= in_b;
            mcand  <= in_a;
            cnt    <= CNT_MUL;
          end else if (is_shift && shamt != '0) begin
            acc_lo <= in_a;
            cnt    <= {1'b0, shamt};
          end else begin
            done <= 1'b1;
            if (alu.wr_out) out   <= alu.r;
            if (alu.wr_c)   CFlag <= alu.c;
            ZeroFlag <= (alu.r == '0);
            SignFlag <= alu.r[MSB];
            VFlag    <= alu.v;
          end
        end
        S_SHIFT: begin
          acc_lo <= sh_nx;
          cnt    <= cnt - CNT_ONE;
          if (last) begin
            done     <= 1'b1;
            out      <= sh_nx;
            CFlag    <= sh_c;
            ZeroFlag <= (sh_nx == '0);
            SignFlag <= sh_nx[MSB];
            VFlag    <= 1'b0;
          end
        end
        S_MUL: begin
          acc_hi <= mul_hi_nx;
          acc_lo <= mul_lo_nx;
          cnt    <= cnt - CNT_ONE;
          if (last) begin
            done     <= 1'b1;
            out      <= mul_lo_nx;
            out_hi   <= mul_hi_nx;
            CFlag    <= |mul_hi_nx;
            VFlag    <= |mul_hi_nx;
            ZeroFlag <= (mul_lo_nx == '0);
            SignFlag <= mul_lo_nx[MSB];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
